// File: rtl/seg7_mux_scheduler_if.sv
// Register-file side of the 7-segment scheduler: display content and brightness.
// master = register file driving the values, slave = the scheduler consuming them.
interface seg7_mux_scheduler_if;
  logic [3:0] digit1_i;
  logic [3:0] digit10_i;
  logic       lz_blank;
  logic       raw_en;
  logic [7:0] raw1;
  logic [7:0] raw10;
  logic [6:0] duty;

  modport master (output digit1_i, digit10_i, lz_blank, raw_en, raw1, raw10, duty);
  modport slave  (input  digit1_i, digit10_i, lz_blank, raw_en, raw1, raw10, duty);
endinterface

// File: rtl/seg7_mux_scheduler.sv
// Two-digit 7-segment multiplexer with PWM brightness.
// Slot = 128 PWM steps of PRESCALE clocks; frame = DIG1 slot then DIG10 slot.
// Content is latched into shadows at each frame start so a frame never tears,
// and PWM step 127 is always dark so the commons never overlap or ghost.
module seg7_mux_scheduler #(
  parameter int PRESCALE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  seg7_mux_scheduler_if.slave  cfg,
  input  logic                 seg_pol,
  input  logic                 com_pol,
  output logic [7:0]           seg_out,
  output logic                 com1_out,
  output logic                 com10_out,
  output logic                 slot,
  output logic                 slot_tick
);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic {S_DIG1 = 1'b0, S_DIG10 = 1'b1} slot_e;

  typedef struct packed {
    logic [6:0] duty;
    logic [3:0] d1;
    logic [3:0] d10;
    logic       lz;
    logic       raw_en;
    logic [7:0] raw1;
    logic [7:0] raw10;
  } shadow_t;

  logic [PW-1:0] r_presc;
  logic [6:0]    r_pwm;
  slot_e         r_slot, w_slot_nxt;
  logic          w_slot_chg;
  shadow_t       r_sh, w_live;
  logic          w_step, w_wrap;
  logic [7:0]    w_pat1, w_pat10, w_pat;
  logic          w_lit;
  logic [7:0]    r_seg;
  logic          r_com1, r_com10, r_tick;

  // Segment pattern {dp,g,f,e,d,c,b,a}; codes above 9 are blank.
  function automatic logic [7:0] dec7(input logic [3:0] c);
    case (c)
      4'd0:    dec7 = 8'h3F;
      4'd1:    dec7 = 8'h06;
      4'd2:    dec7 = 8'h5B;
      4'd3:    dec7 = 8'h4F;
      4'd4:    dec7 = 8'h66;
      4'd5:    dec7 = 8'h6D;
      4'd6:    dec7 = 8'h7D;
      4'd7:    dec7 = 8'h07;
      4'd8:    dec7 = 8'h7F;
      4'd9:    dec7 = 8'h6F;
      default: dec7 = 8'h00;
    endcase
  endfunction

  assign w_live = '{duty: cfg.duty, d1: cfg.digit1_i, d10: cfg.digit10_i,
                    lz: cfg.lz_blank, raw_en: cfg.raw_en,
                    raw1: cfg.raw1, raw10: cfg.raw10};

  assign w_step = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap = w_step && (r_pwm == 7'd127);

  // Prescaler and PWM step counter; pwm_cnt wraps 127->0 on the slot-change step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else if (!ena) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else if (w_step) begin
      r_presc <= '0;
      r_pwm   <= r_pwm + 7'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_slot <= S_DIG1;
    else if (!ena) r_slot <= S_DIG1;
    else           r_slot <= w_slot_nxt;
  end

  // Slot next-state: alternate DIG1/DIG10 at the end of each 128-step slot.
  always_comb begin
    w_slot_nxt = r_slot;
    w_slot_chg = 1'b0;
    if (w_wrap) begin
      w_slot_chg = 1'b1;
      case (r_slot)
        S_DIG1:  w_slot_nxt = S_DIG10;
        default: w_slot_nxt = S_DIG1;
      endcase
    end
  end

  // Shadows follow the inputs while halted, otherwise refresh only at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sh <= '0;
    else if (!ena || (w_slot_chg && r_slot == S_DIG10))
      r_sh <= w_live;
  end

  // Pattern for each digit from the shadowed content.
  always_comb begin
    w_pat1  = r_sh.raw_en ? r_sh.raw1 : dec7(r_sh.d1);
    w_pat10 = dec7(r_sh.d10);
    if (r_sh.raw_en)                     w_pat10 = r_sh.raw10;
    else if (r_sh.lz && r_sh.d10 == 4'd0) w_pat10 = 8'h00;
    w_pat = (r_slot == S_DIG10) ? w_pat10 : w_pat1;
    w_lit = (r_pwm < r_sh.duty) && (w_pat != 8'h00);
  end

  // Registered pad drive (active-high internally) and the slot-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= '0;
      r_com1  <= 1'b0;
      r_com10 <= 1'b0;
      r_tick  <= 1'b0;
    end else if (!ena) begin
      r_seg   <= '0;
      r_com1  <= 1'b0;
      r_com10 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_seg   <= w_lit ? w_pat : 8'h00;
      r_com1  <= w_lit && (r_slot == S_DIG1);
      r_com10 <= w_lit && (r_slot == S_DIG10);
      r_tick  <= w_slot_chg;
    end
  end

  // Polarity straps act after the flops so reset gives inactive pins at once.
  assign seg_out   = r_seg ^ {8{~seg_pol}};
  assign com1_out  = r_com1 ^ ~com_pol;
  assign com10_out = r_com10 ^ ~com_pol;
  assign slot      = r_slot;
  assign slot_tick = r_tick;
endmodule

// File: tb/tb_seg7_mux_scheduler.sv
// Bench for seg7_mux_scheduler (PRESCALE=2): frame-level vector table,
// hand-written corner sequences and randomized runs against a cycle-count model.
module tb_seg7_mux_scheduler;
  localparam int P     = 2;
  localparam int SLOT  = 128 * P;
  localparam int FRAME = 256 * P;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic       seg_pol = 1'b1, com_pol = 1'b1;
  logic [7:0] seg_out;
  logic       com1_out, com10_out, slot, slot_tick;

  seg7_mux_scheduler_if cfg();

  seg7_mux_scheduler #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg(cfg),
    .seg_pol(seg_pol), .com_pol(com_pol),
    .seg_out(seg_out), .com1_out(com1_out), .com10_out(com10_out),
    .slot(slot), .slot_tick(slot_tick));

  always #5 clk = ~clk;

  typedef struct {
    int         duty;
    logic [3:0] d1, d10;
    logic       lz, raw;
    logic [7:0] r1, r10, p1, p10;
  } sh_t;

  logic [7:0] DEC [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int n_vec = 0, n_err = 0;

  // Model: k = clocks since the active sequence (re)started; shadow content per frame.
  int         k = 0;
  sh_t        msh;
  logic [7:0] e_seg = 8'h00;
  logic       e_c1 = 1'b0, e_c10 = 1'b0, e_slot = 1'b0, e_tick = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic sh_t live_in();
    sh_t s;
    s.duty = int'(cfg.duty); s.d1 = cfg.digit1_i; s.d10 = cfg.digit10_i;
    s.lz = cfg.lz_blank; s.raw = cfg.raw_en; s.r1 = cfg.raw1; s.r10 = cfg.raw10;
    s.p1 = 8'h00; s.p10 = 8'h00;
    return s;
  endfunction

  function automatic logic [7:0] pat_of(input sh_t s, input bit tens);
    if (s.raw) return tens ? s.r10 : s.r1;
    if (!tens) return DEC[s.d1];
    if (s.lz && s.d10 == 4'd0) return 8'h00;
    return DEC[s.d10];
  endfunction

  // Predict the pins after the coming edge from the current model state and inputs.
  task automatic model_edge();
    sh_t live;
    live = live_in();
    if (!ena) begin
      e_seg = 8'h00; e_c1 = 1'b0; e_c10 = 1'b0; e_tick = 1'b0; e_slot = 1'b0;
      k = 0; msh = live;
    end else begin
      int pwm;
      bit tens, lit;
      logic [7:0] p;
      pwm  = (k / P) % 128;
      tens = ((k / SLOT) % 2) == 1;
      p    = pat_of(msh, tens);
      lit  = (pwm < msh.duty) && (p != 8'h00);
      e_seg = lit ? p : 8'h00;
      e_c1  = lit && !tens;
      e_c10 = lit && tens;
      k++;
      if (k % FRAME == 0) msh = live;
      e_tick = (k % SLOT) == 0;
      e_slot = ((k / SLOT) % 2) == 1;
    end
  endtask

  task automatic model_reset();
    k = 0; msh = '{default: 0};
    e_seg = 8'h00; e_c1 = 1'b0; e_c10 = 1'b0; e_slot = 1'b0; e_tick = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("pins", {seg_out, com1_out, com10_out, slot, slot_tick},
          {e_seg ^ {8{~seg_pol}}, e_c1 ^ ~com_pol, e_c10 ^ ~com_pol, e_slot, e_tick});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Count lit clocks per common and pattern/overlap errors over n clocks.
  task automatic run_win(input int n, input logic [7:0] p1, input logic [7:0] p10,
                         output int c1, output int c10, output int bad, output int tk);
    logic a1, a10;
    logic [7:0] s;
    c1 = 0; c10 = 0; bad = 0; tk = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      a1  = (com1_out == com_pol);
      a10 = (com10_out == com_pol);
      s   = seg_out ^ {8{~seg_pol}};
      if (a1 && a10)            bad++;
      else if (a1 && s != p1)   bad++;
      else if (a10 && s != p10) bad++;
      else if (!a1 && !a10 && s != 8'h00) bad++;
      c1  += int'(a1);
      c10 += int'(a10);
      tk  += int'(slot_tick);
    end
  endtask

  task automatic set_in(input int duty, input logic [3:0] d1, input logic [3:0] d10,
                        input logic lz, input logic raw, input logic [7:0] r1, input logic [7:0] r10);
    cfg.duty = 7'(duty); cfg.digit1_i = d1; cfg.digit10_i = d10;
    cfg.lz_blank = lz; cfg.raw_en = raw; cfg.raw1 = r1; cfg.raw10 = r10;
  endtask

  task automatic check_inactive(input string name);
    check(name, {seg_out, com1_out, com10_out, slot, slot_tick},
          {seg_pol ? 8'h00 : 8'hFF, ~com_pol, ~com_pol, 1'b0, 1'b0});
  endtask

  task automatic do_reset_release();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  sh_t tbl [8];
  int  c1, c10, bad, tk;

  initial begin
    // duty, d1, d10, lz, raw, raw1, raw10, expected ones pattern, expected tens pattern
    tbl[0] = '{43,  4'd4,  4'd2,  1'b0, 1'b0, 8'h00, 8'h00, 8'h66, 8'h5B};
    tbl[1] = '{0,   4'd4,  4'd2,  1'b0, 1'b0, 8'h00, 8'h00, 8'h66, 8'h5B};
    tbl[2] = '{127, 4'd8,  4'd8,  1'b0, 1'b0, 8'h00, 8'h00, 8'h7F, 8'h7F};
    tbl[3] = '{50,  4'd0,  4'd0,  1'b1, 1'b0, 8'h00, 8'h00, 8'h3F, 8'h00};
    tbl[4] = '{77,  4'd7,  4'd12, 1'b0, 1'b0, 8'h00, 8'h00, 8'h07, 8'h00};
    tbl[5] = '{100, 4'd3,  4'd5,  1'b0, 1'b1, 8'h80, 8'h00, 8'h80, 8'h00};
    tbl[6] = '{1,   4'd0,  4'd1,  1'b1, 1'b0, 8'h00, 8'h00, 8'h3F, 8'h06};
    tbl[7] = '{126, 4'd15, 4'd9,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h6F};

    set_in(0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check_inactive("reset_pins");
    do_reset_release();

    // Frame-level vectors: load shadows with ena low, then one full frame.
    for (int v = 0; v < 8; v++) begin
      set_in(tbl[v].duty, tbl[v].d1, tbl[v].d10, tbl[v].lz, tbl[v].raw, tbl[v].r1, tbl[v].r10);
      ena = 1'b0;
      ticks(3);
      ena = 1'b1;
      run_win(FRAME, tbl[v].p1, tbl[v].p10, c1, c10, bad, tk);
      check($sformatf("v%0d_lit1", v),  c1,  (tbl[v].p1  != 0) ? tbl[v].duty * P : 0);
      check($sformatf("v%0d_lit10", v), c10, (tbl[v].p10 != 0) ? tbl[v].duty * P : 0);
      check($sformatf("v%0d_segs", v),  bad, 0);
      check($sformatf("v%0d_ticks", v), tk,  2);
    end

    // Mid-frame change: current frame keeps old content, next frame shows the new one.
    set_in(43, 4'd4, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    ena = 1'b0; ticks(3); ena = 1'b1;
    run_win(20 * P, 8'h66, 8'h5B, c1, c10, bad, tk);
    set_in(127, 4'd9, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    begin
      int c1b, c10b, badb, tkb;
      run_win(FRAME - 20 * P, 8'h66, 8'h5B, c1b, c10b, badb, tkb);
      check("chg_old_lit1", c1 + c1b, 43 * P);
      check("chg_old_segs", bad + badb, 0);
    end
    run_win(FRAME, 8'h6F, 8'h5B, c1, c10, bad, tk);
    check("chg_new_lit1",  c1,  127 * P);
    check("chg_new_lit10", c10, 127 * P);
    check("chg_new_segs",  bad, 0);

    // ena low for 10 clocks: inactive outputs, restart at DIG1 with fresh shadows.
    run_win(SLOT + 4, 8'h6F, 8'h5B, c1, c10, bad, tk);
    ena = 1'b0;
    ticks(10);
    check_inactive("ena_low_pins");
    set_in(43, 4'd4, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    ticks(1);
    ena = 1'b1;
    run_win(FRAME, 8'h66, 8'h5B, c1, c10, bad, tk);
    check("ena_restart_lit1",  c1,  43 * P);
    check("ena_restart_lit10", c10, 43 * P);

    // Inverted polarity, then asynchronous reset while lit.
    seg_pol = 1'b0; com_pol = 1'b0;
    set_in(127, 4'd4, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    ena = 1'b0; ticks(3); ena = 1'b1;
    ticks(10);
    check("neg_pol_lit", {seg_out, com1_out, com10_out}, {8'h99, 1'b0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check_inactive("async_reset_pins");
    check("async_reset_raw", {seg_out, com1_out, com10_out}, {8'hFF, 1'b1, 1'b1});
    do_reset_release();
    run_win(SLOT, 8'h00, 8'h00, c1, c10, bad, tk);
    check("post_reset_dark", c1 + c10, 0);
    seg_pol = 1'b1; com_pol = 1'b1;

    // Randomized runs against the model (checked every clock inside tick()).
    for (int r = 0; r < 12; r++) begin
      seg_pol = 1'($urandom_range(0, 1));
      com_pol = 1'($urandom_range(0, 1));
      set_in(int'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             8'($urandom), 8'($urandom));
      ena = 1'($urandom_range(0, 3) != 0);
      for (int j = 0; j < 6; j++) begin
        ticks(int'($urandom_range(1, 250)));
        if ($urandom_range(0, 1) == 1) cfg.duty = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 1) == 1) cfg.digit1_i = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) cfg.digit10_i = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) ena = ~ena;
        else ena = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
